// File: rtl/timer_cmp_pkg.sv
// timer_cmp_pkg
// Shared definitions for the timer compare/interrupt unit: register offsets
// as seen on addr[3:2], bit positions inside the CTRL register, the packed
// CTRL record kept by the unit and a helper that formats it as a bus word.
package timer_cmp_pkg;

   // Register index as decoded from the word-aligned bus address
   localparam logic [1:0] REG_CMP_LO = 2'd0;
   localparam logic [1:0] REG_CMP_HI = 2'd1;
   localparam logic [1:0] REG_CTRL   = 2'd2;
   localparam logic [1:0] REG_PERIOD = 2'd3;

   // Bit positions inside the CTRL register
   localparam int CTRL_EN       = 0;
   localparam int CTRL_PERIODIC = 1;
   localparam int CTRL_PEND     = 2;

   // CTRL state held by the unit (packed so en lands in bit 0)
   typedef struct packed {
      logic pend;
      logic periodic;
      logic en;
   } ctrlReg_t;

   // Build the 32-bit read value of CTRL; the upper bits always read zero
   function automatic logic [31:0] ctrlToWord(input ctrlReg_t c);
      logic [31:0] word;
      word                = '0;
      word[CTRL_EN]       = c.en;
      word[CTRL_PERIODIC] = c.periodic;
      word[CTRL_PEND]     = c.pend;
      return word;
   endfunction

endpackage

// File: rtl/timer_cmp.sv
// timer_cmp
// Compare/interrupt unit that watches the free-running 64-bit uptime
// counter. Software programs a 64-bit compare value (committed atomically
// through the CMP_HI write), a 32-bit reload period and a control register.
// When enabled and uptime has reached the compare value, a sticky pending
// flag is set and drives the interrupt line. In periodic mode the compare
// value advances by one period per match cycle; in one-shot mode the
// enable bit drops after the match.
//
// Ports:
//   clock   system clock
//   reset   asynchronous, active-high reset
//   sel     device select, one cycle per bus access
//   we      write enable, qualified by sel
//   addr    byte address, register index taken from addr[ADDR_LSB+1:ADDR_LSB]
//   din     write data (full words only)
//   uptime  current 64-bit uptime, synchronous to clock
//   dout    registered read data, one cycle after a read access
//   irq     level interrupt, straight from the pending flop
module timer_cmp
   import timer_cmp_pkg::*;
#(
   parameter logic [63:0] RESET_CMP = 64'hFFFF_FFFF_FFFF_FFFF,
   parameter int          ADDR_LSB  = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        sel,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] din,
   input  logic [63:0] uptime,
   output logic [31:0] dout,
   output logic        irq
);

   logic [63:0] r_cmp;
   logic [31:0] r_loShadow;
   logic [31:0] r_period;
   ctrlReg_t    r_ctrl;
   logic [31:0] r_dout;

   logic [1:0]  w_regIdx;
   logic        w_wrAccess;
   logic        w_rdAccess;
   logic        w_match;
   logic [63:0] w_reloadCmp;
   logic        w_unusedAddr;

   assign w_regIdx     = addr[ADDR_LSB +: 2];
   assign w_unusedAddr = ^{addr[31:ADDR_LSB+2], addr[ADDR_LSB-1:0]};
   assign w_wrAccess   = sel && we;
   assign w_rdAccess   = sel && !we;

   // Match is checked every cycle against the committed compare value only,
   // so a half-written compare (CMP_LO shadow) can never trigger a match.
   assign w_match     = r_ctrl.en && (uptime >= r_cmp);
   assign w_reloadCmp = r_cmp + {32'b0, r_period};

   // Register state. The automatic match effects are applied first and the
   // software writes afterwards, so that a CMP_HI commit beats a periodic
   // reload and a CTRL write beats the one-shot enable clear. The only
   // exception is PEND: a match in the same cycle as a W1C keeps it set.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_cmp      <= RESET_CMP;
         r_loShadow <= '0;
         r_period   <= '0;
         r_ctrl     <= '0;
      end else begin
         if (w_match) begin
            r_ctrl.pend <= 1'b1;
            if (r_ctrl.periodic) begin
               r_cmp <= w_reloadCmp;
            end else begin
               r_ctrl.en <= 1'b0;
            end
         end

         if (w_wrAccess) begin
            case (w_regIdx)
               REG_CMP_LO: r_loShadow <= din;
               REG_CMP_HI: r_cmp      <= {din, r_loShadow};
               REG_CTRL: begin
                  r_ctrl.en       <= din[CTRL_EN];
                  r_ctrl.periodic <= din[CTRL_PERIODIC];
                  if (din[CTRL_PEND] && !w_match) begin
                     r_ctrl.pend <= 1'b0;
                  end
               end
               REG_PERIOD: r_period <= din;
            endcase
         end
      end
   end

   // Read data register: captured only on a read access, held otherwise.
   // CMP_LO returns the committed low word, not the write shadow.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_dout <= '0;
      end else if (w_rdAccess) begin
         case (w_regIdx)
            REG_CMP_LO: r_dout <= r_cmp[31:0];
            REG_CMP_HI: r_dout <= r_cmp[63:32];
            REG_CTRL:   r_dout <= ctrlToWord(r_ctrl);
            REG_PERIOD: r_dout <= r_period;
         endcase
      end
   end

   assign dout = r_dout;
   assign irq  = r_ctrl.pend;

endmodule

// File: doc/timer_cmp.md
Name: timer_cmp

Overview:
- Memory-mapped compare/interrupt unit downstream of the free-running 64-bit uptime counter.
- Holds a 64-bit compare value, a 32-bit period and a control register.
- Raises a sticky interrupt when uptime reaches the compare value; supports one-shot and periodic (auto-reload) modes.
- Sits on the same CPU peripheral bus as the timer: sel/addr select, registered read data.

Parameters:
- RESET_CMP, 64'hFFFF_FFFF_FFFF_FFFF, compare value after reset (never matches in practice).
- ADDR_LSB, 2, lowest address bit used to decode the register index (word-aligned).

Ports:
- clock   input   1   system clock
- reset   input   1   asynchronous, active-high reset
- sel     input   1   device select from bus decoder, valid for one cycle per access
- we      input   1   write enable, qualified by sel
- addr    input   32  byte address; only addr[3:2] decoded
- din     input   32  write data; full-word writes only
- uptime  input   64  current uptime, synchronous to clock
- dout    output  32  registered read data
- irq     output  1   interrupt request, level, direct flop output

Behaviour:
- Register map (addr[3:2]):
  - 0 CMP_LO: read returns committed cmp[31:0]; write loads lo_shadow only.
  - 1 CMP_HI: read returns cmp[63:32]; write commits cmp <= {din, lo_shadow} atomically.
  - 2 CTRL: bit0 EN, bit1 PERIODIC, bit2 PEND, bits[31:3] read 0.
    - Write sets EN/PERIODIC from din.
    - PEND is write-1-to-clear; writing 0 has no effect.
  - 3 PERIOD: 32-bit read/write reload increment.
- Reset (async): cmp=RESET_CMP, lo_shadow=0, period=0, EN=0, PERIODIC=0, PEND=0, dout=0, irq=0.
- Reads: when sel && !we, dout is updated at the next clock edge (1-cycle latency). dout holds its value otherwise, including on writes.
- Match: match = EN && (uptime >= cmp), 64-bit unsigned compare, evaluated every cycle on committed cmp.
- On a match cycle:
  - PEND <= 1.
  - If PERIODIC: cmp <= cmp + {32'b0, period}, mod 2^64.
  - Otherwise: EN <= 0.
- irq = PEND flop: asserts exactly 1 cycle after the first cycle uptime >= cmp with EN=1.
- Missed periods: at most one reload per cycle; cmp catches up one period per cycle with PEND held high. period=0 in periodic mode keeps cmp fixed and PEND re-set every cycle.
- Simultaneous events:
  - PEND W1C and match in the same cycle: set wins, PEND stays 1.
  - CMP_HI commit and periodic reload in the same cycle: the software commit wins. PEND is still set from the old-cmp match.
  - CTRL write and one-shot EN auto-clear in the same cycle: the written EN value wins.
- Writes to an unmapped offset cannot occur: all 4 offsets are decoded. Accesses without sel are ignored.
- Reset asserted mid-operation clears everything immediately; irq drops asynchronously.

Decomposition:
- Shared package timer_cmp_pkg:
  - register offsets (REG_CMP_LO=0, REG_CMP_HI=1, REG_CTRL=2, REG_PERIOD=3)
  - CTRL bit indices (CTRL_EN=0, CTRL_PERIODIC=1, CTRL_PEND=2)
  - packed struct type for the CTRL fields
- No sub-module: a single always_ff for state and one for dout. The 64-bit compare and the add are inline.

Test Plan:
- Reset, then read all 4 regs -> dout = FFFF_FFFF, FFFF_FFFF, 0, 0; irq=0.
- One-shot:
  - Stimulus: write CMP_LO=100, CMP_HI=0, CTRL=1; ramp uptime 95..105.
  - Expected: irq rises the cycle after uptime=100; CTRL reads 0x4 (EN cleared, PEND set).
  - Then write CTRL=0x4 -> irq=0 next cycle.
- Periodic:
  - Stimulus: cmp=1000, PERIOD=250, CTRL=3; uptime steps by 1.
  - Expected: PEND sets at uptime 1000, 1250, 1500; CMP_LO reads 1250 after the first match.
- Atomic commit:
  - Stimulus: with EN=1 and uptime=0x1_0000_0000, write CMP_LO=0 (hi still all-ones).
  - Expected: no irq; irq fires only after CMP_HI=1 is written.
- Simultaneous W1C and match:
  - Stimulus: write CTRL=0x5 in the same cycle uptime first equals cmp in periodic mode.
  - Expected: PEND remains 1, irq stays high.
- Async reset mid-periodic run:
  - Stimulus: assert reset between clock edges.
  - Expected: irq, dout and all regs cleared before the next edge; no match after release until reprogrammed.
